// File: rtl/cordic_vm_pkg.sv
// cordic_vm_pkg
//   Shared definitions for the time-shared CORDIC vectoring engine:
//   - Q10.15 arctangent table and PI/2 constant
//   - sequencer state encoding
//   - helper that rescales a Q10.15 constant to P_F fractional bits
//   No ports (package).
package cordic_vm_pkg;

    localparam int ATAN_N   = 11;
    localparam int PI_2_Q15 = 51472;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // atan(2^-s) in Q10.15; entries past the table are zero.
    function automatic int atan_q15(input int s);
        case (s)
            0:       return 25736;
            1:       return 15193;
            2:       return 8027;
            3:       return 4075;
            4:       return 2045;
            5:       return 1024;
            6:       return 512;
            7:       return 256;
            8:       return 128;
            9:       return 64;
            10:      return 32;
            default: return 0;
        endcase
    endfunction

    // Truncating rescale from Q10.15 to P_F fractional bits.
    function automatic int rescale_q15(input int v, input int p_f);
        return v >>> (15 - p_f);
    endfunction

endpackage

// File: rtl/cordic_vm_stage.sv
// cordic_vm_stage
//   One combinational vectoring-mode micro-rotation. The direction is
//   chosen to drive u_imag toward zero; the phase accumulator moves by
//   the matching arctangent. All sums wrap at their port width.
// Ports:
//   u_real, u_imag   in   current vector (signed, U_WL)
//   phase            in   current phase accumulator (signed, P_WL)
//   s                in   shift amount for this micro-rotation
//   atan             in   atan(2^-s) already scaled to the phase format
//   u_real_nx, u_imag_nx, phase_nx  out  rotated vector and phase
module cordic_vm_stage #(
    parameter int U_WL = 9,
    parameter int P_WL = 11,
    parameter int S_W  = 3
) (
    input  logic signed [U_WL-1:0] u_real,
    input  logic signed [U_WL-1:0] u_imag,
    input  logic signed [P_WL-1:0] phase,
    input  logic        [S_W-1:0]  s,
    input  logic signed [P_WL-1:0] atan,
    output logic signed [U_WL-1:0] u_real_nx,
    output logic signed [U_WL-1:0] u_imag_nx,
    output logic signed [P_WL-1:0] phase_nx
);

    logic signed [U_WL-1:0] re_sh;
    logic signed [U_WL-1:0] im_sh;

    assign re_sh = u_real >>> s;
    assign im_sh = u_imag >>> s;

    // NOTE: every output gets a value on every path through this block, so
    // no latch is inferred; an if without else here would create one.
    always_comb begin
        if (!u_imag[U_WL-1]) begin
            u_real_nx = u_real + im_sh;
            u_imag_nx = u_imag - re_sh;
            phase_nx  = phase + atan;
        end else begin
            u_real_nx = u_real - im_sh;
            u_imag_nx = u_imag + re_sh;
            phase_nx  = phase - atan;
        end
    end

endmodule

// File: rtl/cordic_vm_sched.sv
// cordic_vm_sched
//   Time-shared iterative CORDIC vectoring-mode phase engine. A round-robin
//   arbiter picks one of N_REQ requesters, the winning vector is pre-rotated
//   into the right half-plane, then ITER micro-rotations run one per clock
//   through a single shared stage. The result is held until taken.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   i_req_valid     per-requester vector valid
//   o_req_ready     one-hot grant; asserted only in IDLE or OUT with i_ready
//   i_u_real/imag   packed inputs, requester k at [k*U_WL +: U_WL]
//   o_valid         result valid
//   i_ready         downstream ready
//   o_phase         signed phase result (Q.P_F)
//   o_id            index of the requester that owns o_phase
module cordic_vm_sched
    import cordic_vm_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int U_WL  = 9,
    parameter  int U_F   = 8,
    parameter  int P_WL  = 11,
    parameter  int P_F   = 7,
    parameter  int ITER  = 5,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*U_WL-1:0]   i_u_real,
    input  logic [N_REQ*U_WL-1:0]   i_u_imag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [P_WL-1:0]  o_phase,
    output logic [ID_W-1:0]         o_id
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic signed [P_WL-1:0] PI_2 = P_WL'(rescale_q15(PI_2_Q15, P_F));

    if (N_REQ < 2 || N_REQ > 8 || ITER < 1 || ITER > ATAN_N ||
        U_F >= U_WL || P_F > 15 || P_F >= P_WL) begin : g_param_check
        $error("cordic_vm_sched: unsupported parameter set");
    end

    state_t                 state_q, state_d;
    logic signed [U_WL-1:0] re_q, im_q;
    logic signed [P_WL-1:0] ph_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ID_W-1:0]        id_q;
    logic [ID_W-1:0]        last_grant_q;

    // ---------------- round-robin arbiter ----------------
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_idx;
    logic             found;
    logic             can_accept;
    logic             accept;

    // Search starts one past the last winner and wraps, so the most
    // recently served requester has the lowest priority.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        rr_idx   = '0;
        found    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_idx = ID_W'((int'(last_grant_q) + i) % N_REQ);
            if (!found && i_req_valid[rr_idx]) begin
                found          = 1'b1;
                grant[rr_idx]  = 1'b1;
                grant_id       = rr_idx;
            end
        end
    end

    // Ready is suppressed while rst is high so nothing is accepted in the
    // reset cycle even though the state register has not cleared yet.
    assign can_accept  = !rst && ((state_q == ST_IDLE) ||
                                  (state_q == ST_OUT && i_ready));
    assign o_req_ready = can_accept ? grant : '0;
    assign accept      = |o_req_ready;

    // ---------------- winner select + pre-rotation ----------------
    logic signed [U_WL-1:0] sel_re, sel_im;
    logic signed [U_WL-1:0] pre_re, pre_im;
    logic signed [P_WL-1:0] pre_ph;

    always_comb begin
        sel_re = '0;
        sel_im = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_re = i_u_real[k*U_WL +: U_WL];
                sel_im = i_u_imag[k*U_WL +: U_WL];
            end
        end
    end

    // Left half-plane vectors are turned by +/-90 degrees so the CORDIC
    // sequence only has to cover the right half-plane. Negation wraps,
    // so the most negative input maps onto itself.
    always_comb begin
        pre_re = sel_re;
        pre_im = sel_im;
        pre_ph = '0;
        if (sel_re[U_WL-1]) begin
            if (!sel_im[U_WL-1]) begin
                pre_re = sel_im;
                pre_im = -sel_re;
                pre_ph = PI_2;
            end else begin
                pre_re = -sel_im;
                pre_im = sel_re;
                pre_ph = -PI_2;
            end
        end
    end

    // ---------------- shared micro-rotation ----------------
    logic signed [U_WL-1:0] rot_re, rot_im;
    logic signed [P_WL-1:0] rot_ph;
    logic signed [P_WL-1:0] atan_cur;

    assign atan_cur = P_WL'(rescale_q15(atan_q15(int'(cnt_q)), P_F));

    cordic_vm_stage #(
        .U_WL (U_WL),
        .P_WL (P_WL),
        .S_W  (CNT_W)
    ) u_stage (
        .u_real    (re_q),
        .u_imag    (im_q),
        .phase     (ph_q),
        .s         (cnt_q),
        .atan      (atan_cur),
        .u_real_nx (rot_re),
        .u_imag_nx (rot_im),
        .phase_nx  (rot_ph)
    );

    // ---------------- sequencer ----------------
    logic last_rot;
    assign last_rot = (cnt_q == CNT_W'(ITER - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_ROT;
            ST_ROT:  if (last_rot) state_d = ST_OUT;
            ST_OUT:  if (i_ready)  state_d = accept ? ST_ROT : ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q         <= '0;
            im_q         <= '0;
            ph_q         <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            re_q         <= pre_re;
            im_q         <= pre_im;
            ph_q         <= pre_ph;
            cnt_q        <= '0;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
        end else if (state_q == ST_ROT) begin
            re_q  <= rot_re;
            im_q  <= rot_im;
            ph_q  <= rot_ph;
            cnt_q <= last_rot ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign o_valid = (state_q == ST_OUT);
    assign o_phase = ph_q;
    assign o_id    = id_q;

endmodule

// File: tb/tb_cordic_vm_sched.sv
// tb_cordic_vm_sched
//   Self-checking bench: table-driven directed vectors, round-robin order,
//   output stall, mid-rotation reset, then random traffic on all requesters
//   compared against an independent reference model via a scoreboard.
module tb_cordic_vm_sched;

    localparam int N  = 4;
    localparam int UW = 9;
    localparam int PW = 11;
    localparam int IT = 5;

    // Phase constants for P_F=7, written out independently of the RTL.
    localparam int PI2_P = 201;
    localparam int ATAN_P [IT] = '{100, 59, 31, 15, 7};

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*UW-1:0]       u_real, u_imag;
    logic                  o_valid;
    logic                  i_ready;
    logic signed [PW-1:0]  o_phase;
    logic [1:0]            o_id;

    logic signed [UW-1:0]  re_a [N];
    logic signed [UW-1:0]  im_a [N];

    always #5 clk = ~clk;

    always_comb begin
        u_real = '0;
        u_imag = '0;
        for (int k = 0; k < N; k++) begin
            u_real[k*UW +: UW] = re_a[k];
            u_imag[k*UW +: UW] = im_a[k];
        end
    end

    cordic_vm_sched dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_u_real    (u_real),
        .i_u_imag    (u_imag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_phase     (o_phase),
        .o_id        (o_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wrap(input int x, input int w);
        int m;
        m = 1 << w;
        x = x & (m - 1);
        if (x >= m / 2) x = x - m;
        return x;
    endfunction

    function automatic int model(input int re, input int im);
        int ph, t, nr, ni;
        ph = 0;
        if (re < 0) begin
            if (im >= 0) begin
                t = re; re = im; im = wrap(-t, UW); ph = PI2_P;
            end else begin
                t = re; re = wrap(-im, UW); im = t; ph = -PI2_P;
            end
        end
        for (int s = 0; s < IT; s++) begin
            if (im >= 0) begin
                nr = wrap(re + (im >>> s), UW);
                ni = wrap(im - (re >>> s), UW);
                ph = wrap(ph + ATAN_P[s], PW);
            end else begin
                nr = wrap(re - (im >>> s), UW);
                ni = wrap(im + (re >>> s), UW);
                ph = wrap(ph - ATAN_P[s], PW);
            end
            re = nr;
            im = ni;
        end
        return ph;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic logic signed [UW-1:0] rnd9();
        if ($urandom_range(0, 7) == 0) return -9'sd256;
        return UW'($urandom_range(0, 511));
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int id;
        int phase;
    } exp_t;

    exp_t         sb_q[$];
    bit           sb_en = 1'b0;
    int           acc_count = 0;
    logic [N-1:0] acc_last = '0;

    // Sampled mid-cycle: handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            acc_last = '0;
        end else begin
            acc_last = req_ready & req_valid;
            if (sb_en) begin
                if (o_valid && i_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_output", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_id", int'(o_id), e.id);
                        check("sb_phase", int'(o_phase), e.phase);
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (acc_last[k]) begin
                        e.id    = k;
                        e.phase = model(int'(re_a[k]), int'(im_a[k]));
                        sb_q.push_back(e);
                        acc_count++;
                    end
                end
            end
        end
    end

    // ---------------- directed single-vector runner ----------------
    typedef struct {
        int id;
        int re;
        int im;
        int ph;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int got, lat;
        @(posedge clk); #1;
        re_a[v.id] = UW'(v.re);
        im_a[v.id] = UW'(v.im);
        req_valid  = N'(1 << v.id);
        i_ready    = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready == req_valid) begin got = 1; break; end
        end
        check({tag, "_grant"}, got, 1);
        if (got == 0) begin
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_valid) begin lat = c; break; end
        end
        check({tag, "_latency"}, lat, IT + 1);
        check({tag, "_phase"}, int'(o_phase), v.ph);
        check({tag, "_id"}, int'(o_id), v.id);
        @(posedge clk);
    endtask

    vec_t vecs [5];

    initial begin
        int n, last_c, lat, id, done;

        vecs[0] = '{id: 0, re: -256, im: -256, ph: -189};
        vecs[1] = '{id: 0, re: 100,  im: 0,    ph: 2};
        vecs[2] = '{id: 1, re: 0,    im: 100,  ph: 198};
        vecs[3] = '{id: 2, re: -100, im: 0,    ph: 399};
        vecs[4] = '{id: 3, re: -100, im: -1,   ph: -399};

        for (int k = 0; k < N; k++) begin
            re_a[k] = '0;
            im_a[k] = '0;
        end

        // ---- reset: ready must stay low even with every request up ----
        rst       = 1'b1;
        req_valid = '1;
        i_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(req_ready), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_phase", int'(o_phase), 0);
        check("rst_id", int'(o_id), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_priority", int'(req_ready), 1);
        #1 req_valid = '0;

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---- round robin with all requesters valid ----
        sb_en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            re_a[k] = UW'(30 * k - 50);
            im_a[k] = UW'(70 - 45 * k);
        end
        req_valid = '1;
        i_ready   = 1'b1;
        n = 0;
        last_c = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                check("rr_onehot", $countones(req_ready), 1);
                check($sformatf("rr_grant%0d", n), oh_idx(req_ready), n % N);
                if (n > 0) check("rr_spacing", c - last_c, IT + 1);
                last_c = c;
                n++;
            end
        end
        check("rr_grants_seen", n, 5);
        @(posedge clk); #1;
        req_valid = '0;
        done = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !o_valid) begin done = 1; break; end
        end
        check("rr_drained", done, 1);
        sb_en = 1'b0;

        // ---- output stall: result held, no grants while blocked ----
        @(posedge clk); #1;
        re_a[0]   = 9'sd100;
        im_a[0]   = 9'sd0;
        req_valid = 4'b0001;
        i_ready   = 1'b0;
        id = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (|req_ready) begin id = oh_idx(req_ready); break; end
        end
        check("stall_grant", id, 0);
        @(posedge clk); #1;
        req_valid = '1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_valid) begin lat = c; break; end
            check("stall_rot_ready", int'(req_ready), 0);
        end
        check("stall_latency", lat, IT + 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid", int'(o_valid), 1);
            check("stall_phase", int'(o_phase), 2);
            check("stall_id", int'(o_id), 0);
            check("stall_ready", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        i_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_release", int'(o_valid), 0);

        // ---- reset during rotation (cnt=2) ----
        @(posedge clk); #1;
        re_a[1]   = 9'sd0;
        im_a[1]   = 9'sd100;
        req_valid = 4'b0010;
        id = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (|req_ready) begin id = oh_idx(req_ready); break; end
        end
        check("mid_rst_grant", id, 1);
        @(posedge clk); #1;   // accept edge: cnt=0
        req_valid = '0;
        @(posedge clk); #1;   // cnt=1
        @(posedge clk); #1;   // cnt=2
        rst       = 1'b1;
        req_valid = '1;
        @(negedge clk);
        check("mid_rst_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_phase", int'(o_phase), 0);
        done = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_valid) done = 0;
        end
        check("mid_rst_discarded", done, 1);
        run_vec(vecs[4], "after_rst");

        // ---- random traffic against the reference model ----
        sb_en = 1'b1;
        acc_count = 0;
        done = 0;
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk); #1;
            i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (acc_last[k]) req_valid[k] = 1'b0;
                if (!req_valid[k]) begin
                    if (acc_count < 2000 && $urandom_range(0, 2) == 0) begin
                        re_a[k]      = rnd9();
                        im_a[k]      = rnd9();
                        req_valid[k] = 1'b1;
                    end
                end else if (!acc_last[k] && $urandom_range(0, 31) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            if (acc_count >= 2000 && req_valid == '0 && sb_q.size() == 0 && !o_valid) begin
                done = 1;
                break;
            end
        end
        check("random_completed", done, 1);
        check("random_enough", int'(acc_count >= 2000), 1);
        check("random_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
